// File: rtl/sound_length_unit.sv
// Multi-channel APU length counter.
// Each channel counts down on the frame-sequencer length tick when length
// enable (single) is set. It clears its enable when the counter reaches zero.
// It also models trigger reload, DAC gating and the extra clock that occurs
// when the length enable is set on an odd sequencer step.
// The channels share no state; each one is a generate instance below.
module sound_length_unit #(
  parameter int             NCH       = 4,
  parameter int             WIDTH_MIN = 6,
  parameter int             WIDTH_MAX = 8,
  parameter logic [NCH-1:0] CH_WIDE   = 4'b0100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         len_tick,
  input  logic                         seq_odd,
  input  logic [NCH-1:0]               trig,
  input  logic [NCH-1:0]               len_wr,
  input  logic [WIDTH_MAX-1:0]         len_data,
  input  logic [NCH-1:0]               single_wr,
  input  logic                         single_data,
  input  logic [NCH-1:0]               dac_on,
  output logic [NCH-1:0]               enable,
  output logic [NCH*(WIDTH_MAX+1)-1:0] remain
);

  // The counter is one bit wider than the widest length field, so a full
  // reload (2^Wi) fits without wrapping.
  localparam int CW = WIDTH_MAX + 1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int             WI   = CH_WIDE[i] ? WIDTH_MAX : WIDTH_MIN;
    localparam logic [CW-1:0]  FULL = CW'(1) << WI;

    logic [CW-1:0] cnt_q;
    logic          single_q;
    logic          en_q;

    logic [CW-1:0] ld, c0, c1, c2, c3;
    logic          s, quirk, dec_tick, zq, zt, en_d;

    // Only the low Wi bits of the written length are meaningful for this channel.
    assign ld = {1'b0, len_data} & (FULL - CW'(1));

    // Step 1: a length write loads FULL minus the value (a value of 0 gives FULL).
    assign c0 = len_wr[i] ? FULL - ld : cnt_q;

    // Step 2: the new length-enable value.
    assign s = single_wr[i] ? single_data : single_q;

    // Step 3: enabling length on an odd step clocks the counter once immediately.
    assign quirk = single_wr[i] && !single_q && single_data && seq_odd && (c0 != '0);
    assign c1    = quirk ? c0 - CW'(1) : c0;

    // Step 4: a trigger on an empty counter reloads it. The reload is one short
    // when length is enabled and the next step will not clock length.
    assign c2 = (trig[i] && (c1 == '0)) ? ((s && seq_odd) ? FULL - CW'(1) : FULL) : c1;

    // Step 5: the frame-sequencer tick counts down. It never wraps past zero.
    assign dec_tick = len_tick && s && (c2 != '0);
    assign c3       = dec_tick ? c2 - CW'(1) : c2;

    // The channel switches off when either the step-3 clock or the tick empties
    // the counter. A trigger in the same cycle overrides the step-3 case,
    // because step 4 has already reloaded the counter.
    assign zq   = quirk && (c1 == '0) && !trig[i];
    assign zt   = dec_tick && (c3 == '0);
    assign en_d = dac_on[i] && (trig[i] || en_q) && !zq && !zt;

    // Channel state register; an asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q    <= '0;
        single_q <= 1'b0;
        en_q     <= 1'b0;
      end else begin
        cnt_q    <= c3;
        single_q <= s;
        en_q     <= en_d;
      end
    end

    assign enable[i]              = en_q;
    assign remain[i*CW +: CW]     = cnt_q;
  end

endmodule

// File: tb/tb_sound_length_unit.sv
// Testbench for sound_length_unit.
// Directed scenarios pin specific values. A randomized phase follows, and every
// cycle is checked against an integer model of the channel rules.
module tb_sound_length_unit;

  localparam int NCH = 4;
  localparam int WMIN = 6;
  localparam int WMAX = 8;
  localparam int CW = WMAX + 1;
  localparam int W = NCH + NCH * CW;
  localparam logic [NCH-1:0] WIDE = 4'b0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              len_tick, seq_odd, single_data;
  logic [NCH-1:0]    trig, len_wr, single_wr, dac_on;
  logic [WMAX-1:0]   len_data;
  logic [NCH-1:0]    enable;
  logic [NCH*CW-1:0] remain;

  sound_length_unit #(
    .NCH(NCH), .WIDTH_MIN(WMIN), .WIDTH_MAX(WMAX), .CH_WIDE(WIDE)
  ) dut (
    .clk(clk), .rst(rst), .len_tick(len_tick), .seq_odd(seq_odd),
    .trig(trig), .len_wr(len_wr), .len_data(len_data),
    .single_wr(single_wr), .single_data(single_data), .dac_on(dac_on),
    .enable(enable), .remain(remain)
  );

  int n_tests = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int m_cnt[NCH];
  bit m_single[NCH];
  bit m_en[NCH];
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      v[NCH*CW + i] = m_en[i];
      v[i*CW +: CW] = CW'(m_cnt[i]);
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_single[i] = 0;
      m_en[i] = 0;
    end
  endtask

  // One clock of a channel, applying the rules in order on plain integers.
  task automatic model_channel(input int i);
    int full, c, ld;
    bit s, off;
    full = 1 << (WIDE[i] ? WMAX : WMIN);
    c = m_cnt[i];
    off = 0;
    if (len_wr[i]) begin
      ld = int'(len_data) % full;
      c = full - ld;
    end
    s = single_wr[i] ? single_data : m_single[i];
    if (single_wr[i] && !m_single[i] && single_data && seq_odd && c != 0) begin
      c = c - 1;
      if (c == 0 && !trig[i]) off = 1;
    end
    if (trig[i] && c == 0) c = (s && seq_odd) ? full - 1 : full;
    if (len_tick && s && c != 0) begin
      c = c - 1;
      if (c == 0) off = 1;
    end
    if (!dac_on[i]) m_en[i] = 0;
    else m_en[i] = (trig[i] || m_en[i]) && !off;
    m_cnt[i] = c;
    m_single[i] = s;
  endtask

  // The model advances on every clock edge and queues the outputs expected after it.
  always @(posedge clk) begin
    if (!rst) model_clear();
    else for (int i = 0; i < NCH; i++) model_channel(i);
    exp_q.push_back(model_vec());
  end

  // An asynchronous reset takes effect at once, so the pending expectation is replaced.
  always @(negedge rst) begin
    model_clear();
    exp_q.delete();
    exp_q.push_back(model_vec());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      exp_v = exp_q.pop_front();
      n_tests++;
      if ({enable, remain} !== exp_v) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t enable/remain got %h expected %h", $time, {enable, remain}, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    len_tick = 0; trig = '0; len_wr = '0; single_wr = '0;
  endtask

  // Advance one clock; the outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rem(input int ch);
    return int'(remain[ch*CW +: CW]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 0; seq_odd = 0; single_data = 0; len_data = '0; dac_on = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_enable", int'(enable), 0);
    check("reset_remain", int'(remain == '0), 1);
    rst = 1;
    dac_on = 4'hF;
    step();

    // Channel 0: load 62 -> 2, enable length and trigger; two ticks switch it off.
    len_wr[0] = 1; len_data = 8'd62; single_wr[0] = 1; single_data = 1; trig[0] = 1;
    step();
    check("s1_load_rem0", rem(0), 2);
    check("s1_load_en0", int'(enable[0]), 1);
    len_tick = 1; step();
    check("s1_tick1_rem0", rem(0), 1);
    check("s1_tick1_en0", int'(enable[0]), 1);
    len_tick = 1; step();
    check("s1_tick2_rem0", rem(0), 0);
    check("s1_tick2_en0", int'(enable[0]), 0);

    // Channel 2 (wide): trigger from empty, extra clock on enable, short reload.
    trig[2] = 1; step();
    check("s2_trig_rem2", rem(2), 256);
    check("s2_trig_en2", int'(enable[2]), 1);
    seq_odd = 1; single_wr[2] = 1; single_data = 1; step();
    check("s2_quirk_rem2", rem(2), 255);
    seq_odd = 0; len_wr[2] = 1; len_data = 8'd255; step();
    check("s2_load_rem2", rem(2), 1);
    len_tick = 1; step();
    check("s2_empty_rem2", rem(2), 0);
    check("s2_empty_en2", int'(enable[2]), 0);
    check("s2_nowrap_rem0", rem(0), 0);
    seq_odd = 1; trig[2] = 1; step();
    check("s2_short_rem2", rem(2), 255);
    check("s2_short_en2", int'(enable[2]), 1);
    seq_odd = 0;

    // Channel 1: the extra clock empties the counter, unless a trigger reloads it.
    len_wr[1] = 1; len_data = 8'd63; trig[1] = 1; step();
    check("s3_load_rem1", rem(1), 1);
    seq_odd = 1; single_wr[1] = 1; single_data = 1; step();
    check("s3_quirk_rem1", rem(1), 0);
    check("s3_quirk_en1", int'(enable[1]), 0);
    seq_odd = 0; single_wr[1] = 1; single_data = 0; len_wr[1] = 1; len_data = 8'd63; trig[1] = 1; step();
    check("s3_reload_rem1", rem(1), 1);
    seq_odd = 1; single_wr[1] = 1; single_data = 1; trig[1] = 1; step();
    check("s3_trig_rem1", rem(1), 63);
    check("s3_trig_en1", int'(enable[1]), 1);
    seq_odd = 0;

    // Channel 3: DAC gating.
    dac_on[3] = 0; trig[3] = 1; step();
    check("s4_dacoff_rem3", rem(3), 64);
    check("s4_dacoff_en3", int'(enable[3]), 0);
    dac_on[3] = 1; trig[3] = 1; step();
    check("s4_dacon_en3", int'(enable[3]), 1);
    dac_on[3] = 0; step();
    check("s4_drop_en3", int'(enable[3]), 0);
    check("s4_drop_rem3", rem(3), 64);
    dac_on[3] = 1;

    // Channel 0: trigger and tick in the same cycle from empty.
    trig[0] = 1; len_tick = 1; step();
    check("s5_rem0", rem(0), 63);
    check("s5_en0", int'(enable[0]), 1);

    // All channels counting, then a reset mid-count.
    len_wr = 4'hF; len_data = 8'd10; single_wr = 4'hF; single_data = 1; trig = 4'hF; step();
    len_tick = 1; step();
    rst = 0;
    #1;
    check("s6_rst_enable", int'(enable), 0);
    check("s6_rst_remain", int'(remain == '0), 1);
    step();
    rst = 1;
    repeat (3) begin len_tick = 1; step(); end
    check("s6_after_enable", int'(enable), 0);
    check("s6_after_remain", int'(remain == '0), 1);

    // Randomized phase, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      len_tick = ($urandom_range(0, 3) == 0);
      seq_odd = $urandom_range(0, 1);
      len_data = WMAX'($urandom_range(0, 255));
      single_data = $urandom_range(0, 1);
      for (int i = 0; i < NCH; i++) begin
        trig[i] = ($urandom_range(0, 7) == 0);
        len_wr[i] = ($urandom_range(0, 9) == 0);
        single_wr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) dac_on[i] = ~dac_on[i];
      end
      if ($urandom_range(0, 199) == 0) rst = 0;
      else if (!rst && $urandom_range(0, 2) == 0) rst = 1;
      @(posedge clk);
      #1;
    end
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
